e203_cg_sched: RTL

Clock-gating scheduler for the E203 core. It generates the per-domain clock enables (IFU, EXU, LSU, BIU) that drive the core clock gates. Each enable has idle hysteresis, so a domain's clock stops only after a programmable run of idle cycles. A WFI sleep sequencer drains the core, gates the IFU, acknowledges sleep and times the wake-up. It sits between the core's activity and WFI signals and the clock-gate cells in the clock-control block.

---
 rtl/e203_cg_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/e203_cg_sched.sv
// Clock-gating scheduler: per-domain clock enables plus the WFI sleep/wake sequencer.
// Define E203_CG_HYST_EN to add the idle-hysteresis hold counters on each enable.
module e203_cg_sched #(
  parameter int IDLE_HOLD = 4,
  parameter int CNT_W     = 4,
  parameter int WAKE_DLY  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic core_cgstop,
  input  logic core_ifu_active,
  input  logic core_exu_active,
  input  logic core_lsu_active,
  input  logic core_biu_active,
  input  logic wfi_req,
  input  logic wakeup,
  output logic ifu_clk_en,
  output logic exu_clk_en,
  output logic lsu_clk_en,
  output logic biu_clk_en,
  output logic core_wfi,
  output logic wfi_ack
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_DLY);

  // Out-of-range counts would silently truncate into the counters.
  if (IDLE_HOLD < 1 || IDLE_HOLD >= (1 << CNT_W) ||
      WAKE_DLY  < 1 || WAKE_DLY  >= (1 << CNT_W)) begin : g_param_check
    $error("e203_cg_sched: IDLE_HOLD/WAKE_DLY out of range for CNT_W");
  end

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] wake_cnt_r;
  logic [CNT_W-1:0] wake_cnt_nxt_s;
  logic             core_wfi_r;
  logic             wfi_ack_r;
  logic [3:0]       act_s;
  logic [3:0]       en_raw_s;
  logic [3:0]       en_s;

  // Domain activity, index 0..3 = IFU, EXU, LSU, BIU; IFU activity is ignored while asleep.
  always_comb begin
    act_s = {core_biu_active, core_lsu_active, core_exu_active,
             core_ifu_active & (state_r != ST_SLEEP)};
  end

  // Sleep sequencer next-state and wake-delay counter.
  always_comb begin
    state_nxt_s    = state_r;
    wake_cnt_nxt_s = wake_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (wfi_req && !wakeup) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Abort takes priority over a completed drain.
        if (wakeup || !wfi_req) begin
          state_nxt_s = ST_RUN;
        end else if (!(core_exu_active || core_lsu_active || core_biu_active)) begin
          state_nxt_s = ST_SLEEP;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_SLEEP: begin
        if (wakeup) begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = WAKE_LOAD;
        end else begin
          state_nxt_s    = ST_SLEEP;
        end
      end
      ST_WAKE: begin
        if (wake_cnt_r <= CNT_W'(1)) begin
          state_nxt_s    = ST_RUN;
          wake_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          state_nxt_s    = ST_WAKE;
          wake_cnt_nxt_s = wake_cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wake_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, wake counter and the registered sleep status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_RUN;
      wake_cnt_r <= {CNT_W{1'b0}};
      core_wfi_r <= 1'b0;
      wfi_ack_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wake_cnt_r <= wake_cnt_nxt_s;
      core_wfi_r <= (state_nxt_s == ST_SLEEP);
      wfi_ack_r  <= (state_nxt_s == ST_SLEEP);
    end
  end

`ifdef E203_CG_HYST_EN
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_HOLD);

  logic [3:0][CNT_W-1:0] hold_r;
  logic [3:0][CNT_W-1:0] hold_nxt_s;

  // Hold counters reload while active and bleed down to zero when idle; IFU hold is flushed on sleep.
  always_comb begin
    hold_nxt_s = hold_r;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 && state_nxt_s == ST_SLEEP) begin
        hold_nxt_s[i] = {CNT_W{1'b0}};
      end else if (act_s[i]) begin
        hold_nxt_s[i] = IDLE_LOAD;
      end else if (hold_r[i] != {CNT_W{1'b0}}) begin
        hold_nxt_s[i] = hold_r[i] - CNT_W'(1);
      end else begin
        hold_nxt_s[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Hold counter registers; reset keeps every clock running for a full hold period.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= {4{IDLE_LOAD}};
    end else begin
      hold_r <= hold_nxt_s;
    end
  end

  // Raw enables: activity or an unexpired hold keeps the clock on.
  always_comb begin
    en_raw_s = {4{1'b0}};
    for (int i = 0; i < 4; i++) begin
      en_raw_s[i] = core_cgstop | act_s[i] | (hold_r[i] != {CNT_W{1'b0}});
    end
  end
`else
  // Raw enables follow activity directly.
  always_comb begin
    en_raw_s = {4{core_cgstop}} | act_s;
  end
`endif

  // IFU enable is overridden by the sleep sequencer; the other domains keep running.
  always_comb begin
    en_s = en_raw_s;
    case (state_r)
      ST_SLEEP: en_s[0] = core_cgstop;
      ST_WAKE:  en_s[0] = 1'b1;
      default:  en_s[0] = en_raw_s[0];
    endcase
  end

  assign ifu_clk_en = en_s[0];
  assign exu_clk_en = en_s[1];
  assign lsu_clk_en = en_s[2];
  assign biu_clk_en = en_s[3];
  assign core_wfi   = core_wfi_r;
  assign wfi_ack    = wfi_ack_r;

endmodule
